// File: rtl/led_pkg.sv
// Shared state encoding and default timing for the LED blink scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_t;

  localparam int DEF_TICK_DIV  = 240;    // 10 us at 24 MHz
  localparam int DEF_ON_TICKS  = 15000;  // 150 ms
  localparam int DEF_OFF_TICKS = 15000;  // 150 ms
  localparam int DEF_GAP_TICKS = 50000;  // 500 ms
  localparam int DEF_PWM_BITS  = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick on wrap; clr realigns it to 0.
module tick_gen
  import led_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST) && !clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (clr || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_sched.sv
// Two-requester LED blink scheduler: round-robin grant, then ON/OFF blinks
// and a dark guard gap, with a low-duty PWM on the granted colour's LED.
module led_sched
  import led_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int PWM_BITS  = DEF_PWM_BITS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [3:0] count0,
  input  logic [3:0] count1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       LED_GREEN,
  output logic       LED_RED
);

  localparam int TW = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS)) + 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

  led_state_t    state_reg, state_next;
  logic [TW-1:0] timer_reg;
  logic [TW-1:0] phase_last;
  logic [3:0]    remain_reg, remain_next;
  logic [3:0]    count_sel;
  logic          colour_reg, colour_next;
  logic          last_reg, last_next;
  logic          armed_reg;
  logic          led_green_reg, led_red_reg;
  logic          tick, phase_done, pwm_on;
  logic          grant_valid, grant_idx;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (grant_valid),
    .tick    (tick)
  );

  // armed_reg holds off grants until one full clock after reset release.
  assign grant_valid = (state_reg == ST_IDLE) && armed_reg && (req != 2'b00);
  assign grant_idx   = (req == 2'b11) ? ~last_reg : req[1];
  assign count_sel   = grant_idx ? count1 : count0;
  assign ack         = grant_valid ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  // Busy also covers the accepting cycle so ack is never seen with busy low.
  assign busy        = (state_reg != ST_IDLE) || grant_valid;

  always_comb begin
    phase_last = GAP_LAST;
    unique case (state_reg)
      ST_ON:   phase_last = ON_LAST;
      ST_OFF:  phase_last = OFF_LAST;
      default: phase_last = GAP_LAST;
    endcase
  end

  assign phase_done = tick && (timer_reg == phase_last);
  assign pwm_on     = (state_reg == ST_ON) && (&timer_reg[PWM_BITS-1:0]);

  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    colour_next = colour_reg;
    last_next   = last_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          last_next   = grant_idx;
          colour_next = grant_idx;
          remain_next = count_sel;
          state_next  = (count_sel == 4'd0) ? ST_GAP : ST_ON;
        end
      end
      ST_ON: begin
        if (phase_done) begin
          state_next  = ST_OFF;
          remain_next = remain_reg - 4'd1;
        end
      end
      ST_OFF: begin
        if (phase_done) begin
          state_next = (remain_reg != 4'd0) ? ST_ON : ST_GAP;
        end
      end
      default: begin
        if (phase_done) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      remain_reg    <= '0;
      colour_reg    <= 1'b0;
      last_reg      <= 1'b1;
      armed_reg     <= 1'b0;
      led_green_reg <= 1'b1;
      led_red_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
      colour_reg <= colour_next;
      last_reg   <= last_next;
      armed_reg  <= 1'b1;
      // Timer restarts on every phase change; it stops at the phase end so never wraps.
      if ((state_next != state_reg) || grant_valid) begin
        timer_reg <= '0;
      end else if (tick && (state_reg != ST_IDLE)) begin
        timer_reg <= timer_reg + 1'b1;
      end
      led_green_reg <= !(pwm_on && !colour_reg);
      led_red_reg   <= !(pwm_on && colour_reg);
    end
  end

  assign LED_GREEN = led_green_reg;
  assign LED_RED   = led_red_reg;

endmodule

// File: tb/tb_led_sched.sv
// Bench for led_sched: cycle-level reference model plus vector table,
// hand-written corner sequences and randomized request traffic.
module tb_led_sched;

  localparam int D   = 4;
  localparam int ONT = 8;
  localparam int OFT = 8;
  localparam int GPT = 16;
  localparam int PWB = 2;
  localparam int PER = (ONT + OFT) * D;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [3:0] count0, count1;
  logic [1:0] ack;
  logic       busy, LED_GREEN, LED_RED;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  led_sched #(
    .TICK_DIV(D), .ON_TICKS(ONT), .OFF_TICKS(OFT), .GAP_TICKS(GPT), .PWM_BITS(PWB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .count0(count0), .count1(count1),
    .ack(ack), .busy(busy), .LED_GREEN(LED_GREEN), .LED_RED(LED_RED)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one active sequence described by grant cycle, count, colour.
  int   m_start  = -100000;
  int   m_n      = 0;
  int   m_end    = -100000;
  logic m_colour = 1'b0;
  logic m_last   = 1'b1;
  logic m_active = 1'b0;
  logic in_reset = 1'b1;
  int   arm_cycle = 1 << 30;

  function automatic bit lit_at(input int c);
    int o, w;
    o = c - (m_start + 1);
    if (o < 0) return 1'b0;
    if (o / PER >= m_n) return 1'b0;
    w = o % PER;
    if (w >= ONT * D) return 1'b0;
    return ((w / D) % (1 << PWB)) == ((1 << PWB) - 1);
  endfunction

  always @(negedge clk) begin
    logic [1:0] e_ack;
    logic       e_busy, e_g, e_r, idx;
    int         cnt;
    e_ack = 2'b00; e_busy = 1'b0; e_g = 1'b1; e_r = 1'b1;
    if (!reset_n) begin
      m_active = 1'b0; m_start = -100000; m_n = 0; m_end = -100000;
      m_last = 1'b1; in_reset = 1'b1; arm_cycle = 1 << 30;
    end else begin
      if (in_reset) begin
        arm_cycle = cyc + 1;
        in_reset  = 1'b0;
      end
      if (lit_at(cyc - 1)) begin
        if (m_colour) e_r = 1'b0; else e_g = 1'b0;
      end
      if (m_active && cyc <= m_end) begin
        e_busy = 1'b1;
      end else begin
        m_active = 1'b0;
        if (req != 2'b00 && cyc >= arm_cycle) begin
          idx = (req == 2'b11) ? ~m_last : req[1];
          cnt = idx ? int'(count1) : int'(count0);
          e_ack = idx ? 2'b10 : 2'b01;
          e_busy = 1'b1;
          m_active = 1'b1; m_start = cyc; m_n = cnt; m_colour = idx; m_last = idx;
          m_end = cyc + (cnt * (ONT + OFT) + GPT) * D;
          $display("cycle %0d: grant idx=%0d count=%0d", cyc, idx, cnt);
        end
      end
    end
    chk("ack", int'(ack), int'(e_ack));
    chk("busy", int'(busy), int'(e_busy));
    chk("led_green", int'(LED_GREEN), int'(e_g));
    chk("led_red", int'(LED_RED), int'(e_r));
    chk("ack_onehot0", int'($onehot0(ack)), 1);
    chk("leds_not_both_low", int'(LED_GREEN | LED_RED), 1);
    chk("timer_bound", int'(dut.timer_reg <= 5'd15), 1);
  end

  task automatic wait_idle();
    @(posedge clk); #1;
    req = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_ack(output int at, output logic [1:0] a);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        at = cyc; a = ack;
        return;
      end
    end
    at = -1; a = 2'b00;
    chk("ack_timeout", 0, 1);
  endtask

  // Assumes req was just driven; drops it after drop_at cycles and measures the sequence.
  task automatic run_seq(input int drop_at, output logic [1:0] a0, output int bn,
                         output int gn, output int rn);
    bn = 0; gn = 0; rn = 0; a0 = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0) a0 = ack;
      if (!busy) return;
      bn++;
      if (!LED_GREEN) gn++;
      if (!LED_RED) rn++;
      @(posedge clk); #1;
      if (k + 1 == drop_at) req = 2'b00;
    end
    chk("seq_timeout", 0, 1);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] c0, c1;
    logic [1:0] e_ack;
    int e_busy, e_glow, e_rlow;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0, t1, t2, rel, acks, bn, gn, rn;
    logic [1:0] a0, a1, a2;

    reset_n = 1'b0; req = 2'b00; count0 = 4'd0; count1 = 4'd0;
    // busy = 1 grant cycle + (blinks*(ON+OFF)+GAP)*TICK_DIV; each blink lights 2 windows of 4 clk.
    vecs[0] = '{2'b01, 4'd2,  4'd0, 2'b01, 193,  16,  0};
    vecs[1] = '{2'b10, 4'd0,  4'd0, 2'b10, 65,   0,   0};
    vecs[2] = '{2'b10, 4'd0,  4'd3, 2'b10, 257,  0,   24};
    vecs[3] = '{2'b11, 4'd1,  4'd1, 2'b01, 129,  8,   0};
    vecs[4] = '{2'b11, 4'd1,  4'd1, 2'b10, 129,  0,   8};
    vecs[5] = '{2'b01, 4'd15, 4'd0, 2'b01, 1025, 120, 0};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_leds", int'({LED_GREEN, LED_RED}), 3);

    // Release with simultaneous requests held: green, red, then green again.
    @(posedge clk); #1;
    reset_n = 1'b1; req = 2'b11; count0 = 4'd1; count1 = 4'd1; rel = cyc;
    wait_ack(t0, a0);
    wait_ack(t1, a1);
    wait_ack(t2, a2);
    chk("first_grant_latency", t0 - rel, 1);
    chk("contend_first", int'(a0), 1);
    chk("contend_second", int'(a1), 2);
    chk("contend_third", int'(a2), 1);
    chk("contend_spacing1", t1 - t0, 129);
    chk("contend_spacing2", t2 - t1, 129);
    wait_idle();

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      req = vecs[i].req; count0 = vecs[i].c0; count1 = vecs[i].c1;
      run_seq(1, a0, bn, gn, rn);
      $display("vector %0d: req=%b ack=%b busy=%0d green_low=%0d red_low=%0d",
               i, vecs[i].req, a0, bn, gn, rn);
      chk("vec_ack", int'(a0), int'(vecs[i].e_ack));
      chk("vec_busy_len", bn, vecs[i].e_busy);
      chk("vec_green_low", gn, vecs[i].e_glow);
      chk("vec_red_low", rn, vecs[i].e_rlow);
      wait_idle();
    end

    // Request dropped during OFF: all three blinks still complete.
    @(posedge clk); #1;
    req = 2'b01; count0 = 4'd3;
    run_seq(40, a0, bn, gn, rn);
    chk("drop_ack", int'(a0), 1);
    chk("drop_busy_len", bn, 257);
    chk("drop_green_low", gn, 24);
    wait_idle();

    // Asynchronous reset while the LED is lit, request held across it.
    @(posedge clk); #1;
    req = 2'b01; count0 = 4'd2;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
        @(negedge clk);
        if (!LED_GREEN) seen = 1'b1;
      end
      chk("led_lit_before_reset", int'(seen), 1);
    end
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_leds", int'({LED_GREEN, LED_RED}), 3);
    chk("async_rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (ack != 2'b00) acks++;
    end
    chk("acks_after_reset", acks, 1);
    wait_idle();

    // Randomized traffic, mid-sequence request changes and occasional resets.
    @(posedge clk); #1;
    for (int s = 0; s < 300; s++) begin
      req = 2'($urandom_range(0, 3));
      count0 = 4'($urandom_range(0, 3));
      count1 = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
      end
      repeat ($urandom_range(1, 60)) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_sched.md
LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 240, meaning clk cycles per 10 us tick at 24 MHz.
REQ-002 SHALL have parameter ON_TICKS, default 15000, meaning the lit phase length in ticks (150 ms).
REQ-003 SHALL have parameter OFF_TICKS, default 15000, meaning the dark phase between blinks in ticks (150 ms).
REQ-004 SHALL have parameter GAP_TICKS, default 50000, meaning the post-sequence dark guard in ticks (500 ms).
REQ-005 SHALL have parameter PWM_BITS, default 7, meaning the dimming period is 2^PWM_BITS ticks.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, PLL output.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port req, input, 2 bits: per-requester blink request; index 0 is green, index 1 is red.
REQ-009 SHALL have port count0 and port count1, input, 4 bits each: blink count for each requester, held stable while its req is high.
REQ-010 SHALL have port ack, output, 2 bits: one-cycle grant-accepted pulse per requester.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port LED_GREEN and port LED_RED, output, 1 bit each: active-low LED drives.

Function
REQ-013 SHALL run a prescaler over 0..TICK_DIV-1 and raise a one-cycle tick when it wraps from TICK_DIV-1 to 0.
REQ-014 SHALL implement a state machine with states IDLE, ON, OFF and GAP.
REQ-015 In IDLE with any req bit high, SHALL grant one requester round-robin, preferring the requester not granted last; after reset, index 0 has priority.
- On grant: pulse ack[i] for exactly one cycle, latch count and colour, clear the phase timer, realign the prescaler to 0.
REQ-016 A granted count of 0 SHALL still pulse ack and go straight to GAP.
REQ-017 On a non-zero grant, the block SHALL enter ON on the cycle after the grant.
REQ-018 ON SHALL last exactly ON_TICKS ticks, then move to OFF and decrement the remaining count.
REQ-019 OFF SHALL last exactly OFF_TICKS ticks, then move to ON if the remaining count is non-zero, otherwise to GAP.
REQ-020 GAP SHALL last exactly GAP_TICKS ticks, then return to IDLE.
REQ-021 SHALL size the phase timer to ceil(log2(max(ON_TICKS, OFF_TICKS, GAP_TICKS)))+1 bits and clear it on every state change.
REQ-022 The phase timer SHALL never wrap within a phase.
REQ-023 The latched colour's LED SHALL be driven low only when the state is ON and phase_timer[PWM_BITS-1:0] is all ones (1/128 duty); the other LED SHALL stay high.
REQ-024 LED outputs SHALL be registered, lagging the state by one clk.
REQ-025 A req that rises or falls outside IDLE SHALL be ignored until IDLE; dropping req mid-sequence SHALL NOT abort the sequence.
REQ-026 If both req bits rise in the same IDLE cycle, SHALL grant one per REQ-015; the other SHALL be granted after the next GAP.
REQ-027 ack SHALL never pulse outside IDLE and never on both bits at once.

Reset
REQ-028 While reset_n is low: state=IDLE, prescaler=0, phase timer=0, round-robin pointer=1 (so index 0 wins first), ack=0, busy=0, LED_GREEN=1, LED_RED=1.
REQ-029 Reset asserted mid-sequence SHALL abort immediately; no ack SHALL be reissued for the aborted request.
REQ-030 After reset_n rises, the first grant SHALL occur no earlier than the second clk edge.

Structure
REQ-031 SHALL place the state encoding and default timing constants (TICK_DIV, ON/OFF/GAP ticks) in a shared led_pkg include.
REQ-032 SHALL place the prescaler in one sub-module, tick_gen, parameterised by TICK_DIV.
- The arbiter and the state machine remain in led_sched.

Verification (TICK_DIV=4, ON=OFF=8, GAP=16, PWM_BITS=2)
REQ-033 req=01, count0=2 -> ack=01 for 1 cycle; LED_GREEN pulses low in two ON windows of 32 clk each; GAP of 64 clk; busy falls after GAP; LED_RED stays 1.
REQ-034 req=11 raised simultaneously, counts 1/1 -> green sequence first; red ack only after green GAP; the next contention grants green again because the pointer alternates.
REQ-035 count1=0, req=10 -> ack=10; busy high for exactly GAP (64 clk) plus 1; no LED activity.
REQ-036 reset_n pulsed low mid-ON -> LEDs=1, busy=0 within the same cycle (asynchronous); req held high -> exactly one new ack after release.
REQ-037 req dropped after ack during OFF, count0=3 -> all 3 blinks complete.
REQ-038 Assertions held throughout:
- ack is one-hot or zero.
- LED_GREEN and LED_RED are never both low.
- Phase timer never exceeds the active phase length.
